// File: rtl/popcount_pkg.sv
// Shared definitions for the frame popcount accumulator: defaults,
// frame-tracking state type and a width-generic saturating adder.
package popcount_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    // Operand width of the saturating adder; accumulators up to 31 bits fit.
    localparam int SAT_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    // Adds a and b, clamps to 2^w-1. Returns {saturated, sum}.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] sum_v;
        logic [SAT_W:0] max_v;
        sum_v = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << w) - 33'd1;
        if (sum_v > max_v) begin
            sat_add = {1'b1, max_v[SAT_W-1:0]};
        end else begin
            sat_add = {1'b0, sum_v[SAT_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/popcount_int16.sv
// Combinational population count of a 16-bit word. IMPL_TYPE 0 uses a
// linear chain of adders, any other value a balanced adder tree.
module popcount_int16 #(
    parameter int IMPL_TYPE = 0
) (
    input  logic [15:0] i_data,
    output logic [4:0]  o_count
);

    generate
        if (IMPL_TYPE == 0) begin : g_chain
            logic [4:0] w_sum;

            // Ripple accumulation of each bit.
            always_comb begin
                w_sum = 5'd0;
                for (int i = 0; i < 16; i++) begin
                    w_sum = w_sum + {4'd0, i_data[i]};
                end
            end

            assign o_count = w_sum;
        end else begin : g_tree
            logic [1:0] w_l1 [8];
            logic [2:0] w_l2 [4];
            logic [3:0] w_l3 [2];

            // Pairwise reduction: bit pairs, then nibbles, then bytes.
            always_comb begin
                for (int i = 0; i < 8; i++) begin
                    w_l1[i] = {1'b0, i_data[2*i]} + {1'b0, i_data[2*i+1]};
                end
                for (int i = 0; i < 4; i++) begin
                    w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
                end
                for (int i = 0; i < 2; i++) begin
                    w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
                end
            end

            assign o_count = {1'b0, w_l3[0]} + {1'b0, w_l3[1]};
        end
    endgenerate

endmodule

// File: rtl/popcount_accum_int16.sv
// Frame-level popcount accumulator: one pipeline register holding the
// per-word count, a saturating frame accumulator and a valid/ready result
// register that can be replaced in the same cycle it is consumed.
module popcount_accum_int16
    import popcount_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic [CNT_WIDTH-1:0] out_words,
    output logic                 out_overflow
);

    generate
        if (WIDTH != 16) begin : g_width_chk
            $error("popcount_accum_int16: WIDTH must be 16");
        end
        if ((CNT_WIDTH < 5) || (CNT_WIDTH > 31)) begin : g_cnt_chk
            $error("popcount_accum_int16: CNT_WIDTH must be in 5..31");
        end
    endgenerate

    logic [4:0]           w_pc;
    logic                 r_s1_valid;
    logic [4:0]           r_s1_pc;
    logic                 r_s1_last;
    logic [CNT_WIDTH-1:0] r_acc_cnt;
    logic [CNT_WIDTH-1:0] r_acc_words;
    logic                 r_acc_ovf;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic [CNT_WIDTH-1:0] r_out_words;
    logic                 r_out_ovf;
    frame_state_e         r_state;
    frame_state_e         w_state_next;

    logic                 w_drain;
    logic                 w_drain_last;
    logic                 w_drain_mid;
    logic                 w_in_fire;
    logic [SAT_W:0]       w_cnt_add;
    logic [SAT_W:0]       w_words_add;
    logic [CNT_WIDTH-1:0] w_cnt_sum;
    logic [CNT_WIDTH-1:0] w_words_sum;
    logic                 w_sat;
    logic                 w_unused;

    popcount_int16 #(
        .IMPL_TYPE (IMPL_TYPE)
    ) u_popcount (
        .i_data  (in_data),
        .o_count (w_pc)
    );

    // A last beat may only leave S1 once the result register is free or
    // being emptied this cycle; non-last beats never wait.
    assign w_drain      = r_s1_valid && !(r_s1_last && r_out_valid && !out_ready);
    assign w_drain_last = w_drain && r_s1_last;
    assign w_drain_mid  = w_drain && !r_s1_last;
    assign in_ready     = !r_s1_valid || w_drain;
    assign w_in_fire    = in_valid && in_ready;

    assign w_cnt_add   = sat_add(SAT_W'(r_acc_cnt), SAT_W'(r_s1_pc), CNT_WIDTH);
    assign w_words_add = sat_add(SAT_W'(r_acc_words), 32'd1, CNT_WIDTH);
    assign w_cnt_sum   = w_cnt_add[CNT_WIDTH-1:0];
    assign w_words_sum = w_words_add[CNT_WIDTH-1:0];
    assign w_sat       = w_cnt_add[SAT_W] | w_words_add[SAT_W];
    // Upper adder bits are always zero after clamping to CNT_WIDTH.
    assign w_unused    = ^{w_cnt_add[SAT_W-1:CNT_WIDTH], w_words_add[SAT_W-1:CNT_WIDTH]};

    assign out_valid    = r_out_valid;
    assign out_count    = r_out_count;
    assign out_words    = r_out_words;
    assign out_overflow = r_out_ovf;

    // S1: capture the per-word popcount, release it when it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_pc    <= 5'd0;
            r_s1_last  <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_pc    <= w_pc;
            r_s1_last  <= in_last;
        end else if (w_drain) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Frame accumulator: add on mid-frame drains, clear when the frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt   <= '0;
            r_acc_words <= '0;
            r_acc_ovf   <= 1'b0;
        end else if (w_drain_last) begin
            r_acc_cnt   <= '0;
            r_acc_words <= '0;
            r_acc_ovf   <= 1'b0;
        end else if (w_drain_mid) begin
            r_acc_cnt   <= w_cnt_sum;
            r_acc_words <= w_words_sum;
            r_acc_ovf   <= r_acc_ovf | w_sat;
        end else begin
            r_acc_cnt   <= r_acc_cnt;
            r_acc_words <= r_acc_words;
            r_acc_ovf   <= r_acc_ovf;
        end
    end

    // Result register: load on frame close (even while being consumed),
    // otherwise drop valid on acceptance and hold the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_words <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_drain_last) begin
            r_out_valid <= 1'b1;
            r_out_count <= w_cnt_sum;
            r_out_words <= w_words_sum;
            r_out_ovf   <= r_acc_ovf | w_sat;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Frame-tracking state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame-tracking next state: any last drain closes the frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_drain_mid) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_drain_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ACTIVE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_popcount_accum_int16.sv
// Bench for popcount_accum_int16: two instances (16-bit and 5-bit counters,
// different popcount implementations) share one stimulus stream; a
// frame-level model pushes expected totals into a queue and a monitor
// compares whenever results are presented.
module tb_popcount_accum_int16;

    typedef struct {
        int c16;
        int w16;
        bit o16;
        int c5;
        int w5;
        bit o5;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_count16, out_words16;
    logic        in_ready5, out_valid5, out_ovf5;
    logic [4:0]  out_count5, out_words5;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_popped = 0;
    int   acc_bits = 0;
    int   acc_n    = 0;
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    popcount_accum_int16 #(.WIDTH(16), .CNT_WIDTH(16), .IMPL_TYPE(0)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_count(out_count16), .out_words(out_words16), .out_overflow(out_ovf16)
    );

    popcount_accum_int16 #(.WIDTH(16), .CNT_WIDTH(5), .IMPL_TYPE(1)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid5), .out_ready(out_ready),
        .out_count(out_count5), .out_words(out_words5), .out_overflow(out_ovf5)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Frame-level reference: totals of the frame's bits and words, clamped.
    task automatic model_accept(input logic [15:0] d, input logic l);
        exp_t e;
        acc_bits += $countones(d);
        acc_n    += 1;
        if (l) begin
            e.c16 = clamp(acc_bits, 65535);
            e.w16 = clamp(acc_n, 65535);
            e.o16 = (acc_bits > 65535) || (acc_n > 65535);
            e.c5  = clamp(acc_bits, 31);
            e.w5  = clamp(acc_n, 31);
            e.o5  = (acc_bits > 31) || (acc_n > 31);
            exp_q.push_back(e);
            acc_bits = 0;
            acc_n    = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the word transfers.
    task automatic send_word(input logic [15:0] d, input logic l, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready16 && in_ready5) begin
                @(posedge clk);
                model_accept(d, l);
                @(negedge clk);
                break;
            end
            stalls++;
            if (stalls > 200) begin
                chk("send_timeout", stalls, 0);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Monitor: compare the presented result with the oldest expected frame.
    always @(negedge clk) begin
        #2;
        if (rst_n && (out_valid16 || out_valid5)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                chk("valid16", out_valid16, 1);
                chk("count16", out_count16, exp_q[0].c16);
                chk("words16", out_words16, exp_q[0].w16);
                chk("ovf16",   out_ovf16,   exp_q[0].o16);
                chk("valid5",  out_valid5,  1);
                chk("count5",  out_count5,  exp_q[0].c5);
                chk("words5",  out_words5,  exp_q[0].w5);
                chk("ovf5",    out_ovf5,    exp_q[0].o5);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int stall_sum;
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid16, 0);
        chk("rst_out_count", out_count16, 0);
        chk("rst_out_words", out_words16, 0);
        chk("rst_out_ovf",   out_ovf16,   0);
        chk("rst_in_ready",  in_ready16,  1);
        chk("rst_out_valid5", out_valid5, 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Single-word frame and two-edge latency.
        out_ready = 1'b1;
        send_word(16'hFFFF, 1'b1, st);
        in_valid = 1'b0;
        chk("latency_not_yet", out_valid16, 0);
        @(negedge clk);
        chk("latency_visible", out_valid16, 1);
        @(negedge clk);

        // Three-word frame back to back: no stalls.
        stall_sum = 0;
        send_word(16'h0001, 1'b0, st); stall_sum += st;
        send_word(16'h00FF, 1'b0, st); stall_sum += st;
        send_word(16'hAAAA, 1'b1, st); stall_sum += st;
        in_valid = 1'b0;
        chk("frame3_stalls", stall_sum, 0);
        repeat (3) @(negedge clk);

        // Back-pressure: second frame's last word stalls in S1.
        out_ready = 1'b0;
        stall_sum = 0;
        send_word(16'h000F, 1'b0, st); stall_sum += st;
        send_word(16'h0003, 1'b1, st); stall_sum += st;
        send_word(16'h8000, 1'b0, st); stall_sum += st;
        send_word(16'h0001, 1'b1, st); stall_sum += st;
        in_valid = 1'b0;
        chk("bp_accept_stalls", stall_sum, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk("bp_in_ready_low", in_ready16, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1 chk("bp_in_ready_back", in_ready16, 1);
        chk("bp_second_valid", out_valid16, 1);
        repeat (2) @(negedge clk);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Saturation (visible on the 5-bit instance), then a clean frame.
        send_word(16'hFFFF, 1'b0, st);
        send_word(16'hFFFF, 1'b0, st);
        send_word(16'hFFFF, 1'b1, st);
        send_word(16'h0001, 1'b1, st);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame with a held result.
        out_ready = 1'b0;
        send_word(16'h00F0, 1'b1, st);
        send_word(16'h00FF, 1'b0, st);
        send_word(16'h00FF, 1'b0, st);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        exp_q.delete();
        acc_bits = 0;
        acc_n    = 0;
        #1;
        chk("mid_rst_valid", out_valid16, 0);
        chk("mid_rst_count", out_count16, 0);
        chk("mid_rst_words", out_words16, 0);
        chk("mid_rst_ovf",   out_ovf16,   0);
        chk("mid_rst_count5", out_count5, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send_word(16'h0003, 1'b1, st);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_empty", exp_q.size(), 0);

        // Streaming single-word frames: result register never empties.
        base      = n_popped;
        stall_sum = 0;
        for (int i = 0; i < 8; i++) begin
            send_word(16'h0101, 1'b1, st);
            stall_sum += st;
            if (i >= 1) chk("stream_valid_high", out_valid16, 1);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_stalls", stall_sum, 0);
        chk("stream_results", n_popped - base, 8);

        // Randomized frames with random back-pressure and idle gaps.
        rand_rdy = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                send_word(16'($urandom), (k == len - 1), st);
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    in_last  = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        end
        in_valid  = 1'b0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_out_valid", out_valid16, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
